// File: rtl/gpu_pkg.sv
// Shared GPU core definitions: scheduler phase encodings, fetcher states and
// the instruction width. The decoder imports the same package.
package gpu_pkg;
  localparam int INSTR_W = 16;

  localparam logic [2:0] CORE_IDLE    = 3'b000;
  localparam logic [2:0] CORE_FETCH   = 3'b001;
  localparam logic [2:0] CORE_DECODE  = 3'b010;
  localparam logic [2:0] CORE_REQUEST = 3'b011;
  localparam logic [2:0] CORE_WAIT    = 3'b100;
  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam logic [2:0] CORE_DONE    = 3'b111;

  typedef enum logic [2:0] {
    FS_IDLE     = 3'b000,
    FS_FETCHING = 3'b001,
    FS_FETCHED  = 3'b010
  } fetch_state_e;
endpackage

// File: rtl/fetch_ibuf.sv
// Direct-mapped instruction buffer: combinational lookup, synchronous fill,
// flush clears every valid bit and wins over a coincident fill.
module fetch_ibuf
  import gpu_pkg::*;
#(
  parameter int ADDR_BITS = 8,
  parameter int DATA_BITS = INSTR_W,
  parameter int LINES     = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_flush,
  input  logic [ADDR_BITS-1:0] i_rd_pc,
  output logic                 o_hit,
  output logic [DATA_BITS-1:0] o_data,
  input  logic                 i_wr_en,
  input  logic [ADDR_BITS-1:0] i_wr_pc,
  input  logic [DATA_BITS-1:0] i_wr_data
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_BITS - IDX_W;

  logic [LINES-1:0]     r_valid;
  logic [TAG_W-1:0]     r_tag  [LINES];
  logic [DATA_BITS-1:0] r_data [LINES];

  logic [IDX_W-1:0] w_rd_idx, w_wr_idx;
  logic [TAG_W-1:0] w_rd_tag, w_wr_tag;

  assign w_rd_idx = i_rd_pc[IDX_W-1:0];
  assign w_rd_tag = i_rd_pc[ADDR_BITS-1:IDX_W];
  assign w_wr_idx = i_wr_pc[IDX_W-1:0];
  assign w_wr_tag = i_wr_pc[ADDR_BITS-1:IDX_W];

  // A flush in the lookup cycle must force a miss, not just clear afterwards.
  assign o_hit  = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag) && !i_flush;
  assign o_data = r_data[w_rd_idx];

  always_ff @(posedge clk) begin
    if (reset || i_flush) begin
      r_valid <= '0;
    end else if (i_wr_en) begin
      r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_data;
    end
  end
endmodule

// File: rtl/fetcher.sv
// Instruction-fetch stage: serves FETCH from the instruction buffer or a
// program-memory read, then holds the instruction for the decoder.
module fetcher
  import gpu_pkg::*;
#(
  parameter int PROG_MEM_ADDR_BITS = 8,
  parameter int PROG_MEM_DATA_BITS = INSTR_W,
  parameter int IBUF_LINES         = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [2:0]                    core_state,
  input  logic [PROG_MEM_ADDR_BITS-1:0] current_pc,
  input  logic                          flush,
  output logic                          mem_read_valid,
  output logic [PROG_MEM_ADDR_BITS-1:0] mem_read_address,
  input  logic                          mem_read_ready,
  input  logic [PROG_MEM_DATA_BITS-1:0] mem_read_data,
  output logic [2:0]                    fetcher_state,
  output logic [PROG_MEM_DATA_BITS-1:0] instruction,
  output logic                          ibuf_hit
);
  fetch_state_e                  r_state;
  logic                          r_valid;
  logic [PROG_MEM_ADDR_BITS-1:0] r_addr;
  logic [PROG_MEM_DATA_BITS-1:0] r_instr;
  logic                          r_hit;

  logic                          w_hit;
  logic [PROG_MEM_DATA_BITS-1:0] w_hit_data;
  logic                          w_fill;

  assign w_fill = (r_state == FS_FETCHING) && mem_read_ready;

  fetch_ibuf #(
    .ADDR_BITS (PROG_MEM_ADDR_BITS),
    .DATA_BITS (PROG_MEM_DATA_BITS),
    .LINES     (IBUF_LINES)
  ) u_ibuf (
    .clk       (clk),
    .reset     (reset),
    .i_flush   (flush),
    .i_rd_pc   (current_pc),
    .o_hit     (w_hit),
    .o_data    (w_hit_data),
    .i_wr_en   (w_fill),
    .i_wr_pc   (r_addr),
    .i_wr_data (mem_read_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FS_IDLE;
      r_valid <= 1'b0;
      r_addr  <= '0;
      r_instr <= '0;
      r_hit   <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        FS_IDLE: begin
          if (core_state == CORE_FETCH) begin
            if (w_hit) begin
              r_instr <= w_hit_data;
              r_hit   <= 1'b1;
              r_state <= FS_FETCHED;
            end else begin
              r_valid <= 1'b1;
              r_addr  <= current_pc;
              r_state <= FS_FETCHING;
            end
          end
        end
        FS_FETCHING: begin
          if (mem_read_ready) begin
            r_instr <= mem_read_data;
            r_valid <= 1'b0;
            r_state <= FS_FETCHED;
          end
        end
        FS_FETCHED: begin
          if (core_state == CORE_DECODE) r_state <= FS_IDLE;
        end
        default: r_state <= FS_IDLE;
      endcase
    end
  end

  assign mem_read_valid   = r_valid;
  assign mem_read_address = r_addr;
  assign fetcher_state    = r_state;
  assign instruction      = r_instr;
  assign ibuf_hit         = r_hit;
endmodule
